calc_stream_controller: RTL and testbench

Parametrised successor of the calculator sequencing controller. It streams operand-pair words from a read address window and drives the operands to an external combinational ALU. It packs PACK = MEM_WORD_SIZE/DATA_W results per memory word and writes the packed words into a write window. New over the previous generation:
- start/busy/done handshake with re-arm
- configurable read latency
- add/sub mode
- partial-word flush
- write-window overflow and range-error reporting

---
 rtl/calculator_pkg.sv | 18 +
 rtl/calc_result_packer.sv | 37 +++
 rtl/calc_stream_controller.sv | 197 +++++++++++++++++++
 tb/tb_calc_stream_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calculator_pkg.sv
// Shared types and default sizing for the calculator stream controller family.
package calculator_pkg;

    localparam int unsigned ADDR_W        = 5;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned MEM_WORD_SIZE = 64;
    localparam int unsigned PACK          = MEM_WORD_SIZE / DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RWAIT,
        S_EXEC,
        S_WRITE,
        S_DONE
    } ctrl_state_t;

endpackage

// File: rtl/calc_result_packer.sv
// Collects PACK results of DATA_W bits into one memory word; slot 0 sits in the LSBs.
module calc_result_packer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PACK   = 2,
    parameter int unsigned SLOT_W = (PACK > 1) ? $clog2(PACK) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear,
    input  logic                   capture,
    input  logic [SLOT_W-1:0]      slot,
    input  logic [DATA_W-1:0]      result,
    output logic [PACK*DATA_W-1:0] packed_word
);

    logic [DATA_W-1:0] slots_q [PACK];

    // Slot storage; clearing zeroes every slot so a partial word is zero-padded.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            for (int i = 0; i < int'(PACK); i++) begin
                slots_q[i] <= '0;
            end
        end else if (capture) begin
            slots_q[slot] <= result;
        end
    end

    // Flatten the slots into the packed output word.
    always_comb begin
        packed_word = '0;
        for (int i = 0; i < int'(PACK); i++) begin
            packed_word[i*DATA_W +: DATA_W] = slots_q[i];
        end
    end

endmodule

// File: rtl/calc_stream_controller.sv
// Streams operand pairs from a read window through an external ALU and writes
// packed results into a write window, with start/busy/done handshake and error flags.
module calc_stream_controller
    import calculator_pkg::*;
#(
    parameter int unsigned ADDR_W        = calculator_pkg::ADDR_W,
    parameter int unsigned DATA_W        = calculator_pkg::DATA_W,
    parameter int unsigned MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE,
    parameter int unsigned RD_LAT        = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic [ADDR_W-1:0]        read_start_addr,
    input  logic [ADDR_W-1:0]        read_end_addr,
    input  logic [ADDR_W-1:0]        write_start_addr,
    input  logic [ADDR_W-1:0]        write_end_addr,
    output logic                     read,
    output logic [ADDR_W-1:0]        r_addr,
    input  logic [MEM_WORD_SIZE-1:0] r_data,
    output logic                     write,
    output logic [ADDR_W-1:0]        w_addr,
    output logic [MEM_WORD_SIZE-1:0] w_data,
    output logic [DATA_W-1:0]        op_a,
    output logic [DATA_W-1:0]        op_b,
    output logic                     op_sub,
    input  logic [DATA_W-1:0]        alu_result,
    output logic                     busy,
    output logic                     done,
    output logic                     err_range,
    output logic                     err_overflow
);

    localparam int unsigned WORD_SLOTS = MEM_WORD_SIZE / DATA_W;
    localparam int unsigned SLOT_W     = (WORD_SLOTS > 1) ? $clog2(WORD_SLOTS) : 1;
    localparam int unsigned CNT_W      = 3;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WORD_SLOTS - 1);

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] r_ptr_q, r_ptr_d, w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0] r_end_q, r_end_d, w_end_q, w_end_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic              mode_q, mode_d;
    logic              err_range_q, err_range_d, err_ovf_q, err_ovf_d;
    logic              pk_clear, pk_capture;
    logic [MEM_WORD_SIZE-1:0] packed_word;

    calc_result_packer #(
        .DATA_W (DATA_W),
        .PACK   (WORD_SLOTS),
        .SLOT_W (SLOT_W)
    ) u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear       (pk_clear),
        .capture     (pk_capture),
        .slot        (slot_q),
        .result      (alu_result),
        .packed_word (packed_word)
    );

    // State, pointers, latency counter, operand and flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            r_ptr_q     <= '0;
            w_ptr_q     <= '0;
            r_end_q     <= '0;
            w_end_q     <= '0;
            slot_q      <= '0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            mode_q      <= 1'b0;
            err_range_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_ptr_q     <= r_ptr_d;
            w_ptr_q     <= w_ptr_d;
            r_end_q     <= r_end_d;
            w_end_q     <= w_end_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            mode_q      <= mode_d;
            err_range_q <= err_range_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    // Next-state logic and memory strobes; pointers never wrap past the inclusive ends.
    always_comb begin
        state_d     = state_q;
        r_ptr_d     = r_ptr_q;
        w_ptr_d     = w_ptr_q;
        r_end_d     = r_end_q;
        w_end_d     = w_end_q;
        slot_d      = slot_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        mode_d      = mode_q;
        err_range_d = err_range_q;
        err_ovf_d   = err_ovf_q;
        read        = 1'b0;
        r_addr      = '0;
        write       = 1'b0;
        w_addr      = '0;
        w_data      = '0;
        done        = 1'b0;
        pk_clear    = 1'b0;
        pk_capture  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d      = mode_i;
                    r_end_d     = read_end_addr;
                    w_end_d     = write_end_addr;
                    err_range_d = 1'b0;
                    err_ovf_d   = 1'b0;
                    if ((read_start_addr > read_end_addr) ||
                        (write_start_addr > write_end_addr)) begin
                        err_range_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        r_ptr_d = read_start_addr;
                        w_ptr_d = write_start_addr;
                        slot_d  = '0;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                read    = 1'b1;
                r_addr  = r_ptr_q;
                cnt_d   = CNT_W'(RD_LAT - 1);
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (cnt_q == '0) begin
                    op_a_d  = r_data[DATA_W-1:0];
                    op_b_d  = r_data[2*DATA_W-1:DATA_W];
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_EXEC: begin
                pk_capture = 1'b1;
                if ((slot_q == LAST_SLOT) || (r_ptr_q == r_end_q)) begin
                    state_d = S_WRITE;
                end else begin
                    slot_d  = slot_q + 1'b1;
                    r_ptr_d = r_ptr_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_WRITE: begin
                write    = 1'b1;
                w_addr   = w_ptr_q;
                w_data   = packed_word;
                pk_clear = 1'b1;
                slot_d   = '0;
                if (r_ptr_q == r_end_q) begin
                    state_d = S_DONE;
                end else if (w_ptr_q == w_end_q) begin
                    // Reads remain but there is nowhere left to write them.
                    err_ovf_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    w_ptr_d = w_ptr_q + 1'b1;
                    r_ptr_d = r_ptr_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign op_sub       = mode_q;
    assign err_range    = err_range_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_calc_stream_controller.sv
// Bench for calc_stream_controller: two instances (read latency 1 and 3), each with
// a latency-accurate memory model and an external ALU; writes and reads are
// scoreboarded against queues filled when each run is launched.
module tb_calc_stream_controller;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MW = 64;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [MW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start [2];
    logic          mode;
    logic [AW-1:0] rs, re, ws, we;

    logic          read [2], write [2], op_sub [2], busy [2], done [2];
    logic          err_range [2], err_overflow [2];
    logic [AW-1:0] r_addr [2], w_addr [2];
    logic [MW-1:0] r_data [2], w_data [2];
    logic [DW-1:0] op_a [2], op_b [2], alu_result [2];

    logic [MW-1:0] mem [2][32];

    wr_t           exp_q [$];
    logic [AW-1:0] rd_q [$];
    int            rd_cnt [2];
    int            wr_cnt [2];
    int            n_checks = 0;
    int            n_pass = 0;

    initial forever #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        logic [MW-1:0] pipe [LAT];
        logic          vld [LAT];

        calc_stream_controller #(
            .ADDR_W        (AW),
            .DATA_W        (DW),
            .MEM_WORD_SIZE (MW),
            .RD_LAT        (LAT)
        ) u_dut (
            .clk_i            (clk),
            .rst_i            (rst),
            .start_i          (start[g]),
            .mode_i           (mode),
            .read_start_addr  (rs),
            .read_end_addr    (re),
            .write_start_addr (ws),
            .write_end_addr   (we),
            .read             (read[g]),
            .r_addr           (r_addr[g]),
            .r_data           (r_data[g]),
            .write            (write[g]),
            .w_addr           (w_addr[g]),
            .w_data           (w_data[g]),
            .op_a             (op_a[g]),
            .op_b             (op_b[g]),
            .op_sub           (op_sub[g]),
            .alu_result       (alu_result[g]),
            .busy             (busy[g]),
            .done             (done[g]),
            .err_range        (err_range[g]),
            .err_overflow     (err_overflow[g])
        );

        assign alu_result[g] = op_sub[g] ? (op_a[g] - op_b[g]) : (op_a[g] + op_b[g]);

        // Memory returns data exactly LAT cycles after the strobe, garbage otherwise.
        always @(posedge clk) begin
            pipe[0] <= mem[g][r_addr[g]];
            vld[0]  <= read[g];
            for (int k = 1; k < int'(LAT); k++) begin
                pipe[k] <= pipe[k-1];
                vld[k]  <= vld[k-1];
            end
        end
        assign r_data[g] = vld[LAT-1] ? pipe[LAT-1] : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] alu_ref(input int inst, input logic m, input int a);
        logic [MW-1:0] w;
        w = mem[inst[0]][a[AW-1:0]];
        return m ? (w[DW-1:0] - w[MW-1:DW]) : (w[DW-1:0] + w[MW-1:DW]);
    endfunction

    function automatic bit any_nonzero(input int i);
        return busy[i] || done[i] || read[i] || write[i] || err_range[i] ||
               err_overflow[i] || op_sub[i] || (op_a[i] != '0) || (op_b[i] != '0) ||
               (w_data[i] != '0) || (w_addr[i] != '0) || (r_addr[i] != '0);
    endfunction

    // Scoreboard: pop expected reads/writes as the DUTs issue them.
    always @(negedge clk) begin
        wr_t           e;
        logic [AW-1:0] a;
        for (int i = 0; i < 2; i++) begin
            if (read[i]) begin
                rd_cnt[i]++;
                if (rd_q.size() == 0) check("spurious_read", 1, 0);
                else begin
                    a = rd_q.pop_front();
                    check("r_addr", r_addr[i], a);
                end
            end
            if (write[i]) begin
                wr_cnt[i]++;
                if (exp_q.size() == 0) check("spurious_write", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("w_addr", w_addr[i], e.addr);
                    check("w_data", w_data[i], e.data);
                end
            end
        end
    end

    task automatic run(input int inst, input logic m, input int rsa, input int rea,
                       input int wsa, input int wea, input bit timing, input bit poke);
        int            n, cap, nr, nw, cyc, rd_cyc, rd0, wr0, lat;
        bit            rng, ovf, seen;
        logic [DW-1:0] lo, hi, first_a;
        wr_t           e;
        lat = (inst == 0) ? 1 : 3;
        rng = (rsa > rea) || (wsa > wea);
        nr = 0;
        nw = 0;
        ovf = 1'b0;
        if (!rng) begin
            n   = rea - rsa + 1;
            cap = 2 * (wea - wsa + 1);
            nr  = (n < cap) ? n : cap;
            ovf = (n > cap);
            for (int k = 0; k < nr; k++) rd_q.push_back(AW'(rsa + k));
            for (int k = 0; k < nr; k += 2) begin
                lo = alu_ref(inst, m, rsa + k);
                hi = (k + 1 < nr) ? alu_ref(inst, m, rsa + k + 1) : '0;
                e.addr = AW'(wsa + k / 2);
                e.data = {hi, lo};
                exp_q.push_back(e);
                nw++;
            end
        end
        first_a = mem[inst[0]][rsa[AW-1:0]][DW-1:0];
        rd0 = rd_cnt[inst];
        wr0 = wr_cnt[inst];
        @(negedge clk);
        mode = m;
        rs = AW'(rsa);
        re = AW'(rea);
        ws = AW'(wsa);
        we = AW'(wea);
        start[inst] = 1'b1;
        cyc = 1;
        rd_cyc = -100;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            start[inst] = 1'b0;
            cyc++;
            if (poke && cyc == 4) begin
                start[inst] = 1'b1;
                mode = ~m;
                rs = 0;
                re = 7;
                ws = 20;
                we = 31;
            end else if (poke && cyc == 5) begin
                mode = m;
            end
            if (read[inst] && rd_cyc < 0) rd_cyc = cyc;
            if (timing && cyc == rd_cyc + lat)
                check("op_a_before_capture", op_a[inst] == first_a, 0);
            if (timing && cyc == rd_cyc + lat + 1)
                check("op_a_captured", op_a[inst], first_a);
            if (done[inst]) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        check("cycles", cyc, nr * (2 + lat) + nw + 2);
        check("busy_at_done", busy[inst], 1);
        check("err_range", err_range[inst], rng);
        check("err_overflow", err_overflow[inst], ovf);
        @(negedge clk);
        check("done_one_cycle", done[inst], 0);
        check("busy_after_done", busy[inst], 0);
        check("err_range_sticky", err_range[inst], rng);
        check("err_overflow_sticky", err_overflow[inst], ovf);
        check("read_count", rd_cnt[inst] - rd0, nr);
        check("write_count", wr_cnt[inst] - wr0, nw);
        check("scoreboard_drained", exp_q.size() + rd_q.size(), 0);
    endtask

    initial begin
        int cnt, rd0, wr0;
        rst = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        mode = 1'b0;
        rs = '0;
        re = '0;
        ws = '0;
        we = '0;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 32; a++) mem[i][a] = {$urandom, $urandom};
        mem[0][0] = {32'd2, 32'd1};
        mem[0][1] = {32'd4, 32'd3};
        mem[0][2] = {32'd6, 32'd5};
        mem[0][3] = {32'd8, 32'd7};
        mem[0][4] = {32'd3, 32'd10};
        mem[0][5] = {32'd1, 32'd0};
        mem[0][6] = {32'd9, 32'd9};
        mem[1][0] = {32'd1, 32'hFFFF_FFFF};

        repeat (3) @(negedge clk);
        check("reset_outputs_0", any_nonzero(0), 0);
        check("reset_outputs_1", any_nonzero(1), 0);
        rst = 1'b0;
        @(negedge clk);

        run(0, 1'b0, 0, 3, 10, 11, 1'b0, 1'b0);   // add, two full words
        run(0, 1'b1, 4, 6, 0, 1, 1'b0, 1'b0);     // sub, zero-padded partial word
        run(0, 1'b0, 5, 2, 0, 1, 1'b0, 1'b0);     // read range inverted
        run(0, 1'b0, 0, 1, 3, 2, 1'b0, 1'b0);     // write range inverted
        run(0, 1'b0, 0, 5, 20, 20, 1'b0, 1'b0);   // write window overflow
        run(0, 1'b1, 30, 31, 31, 31, 1'b0, 1'b0); // ends at all-ones address

        // Reset during the read wait of the second word aborts with no write.
        rd0 = rd_cnt[0];
        wr0 = wr_cnt[0];
        rd_q.push_back(AW'(0));
        rd_q.push_back(AW'(1));
        @(negedge clk);
        mode = 1'b0;
        rs = 0;
        re = 3;
        ws = 10;
        we = 11;
        start[0] = 1'b1;
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 2; c++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (read[0]) cnt++;
        end
        check("rst_second_read_seen", cnt, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_outputs_cleared", any_nonzero(0), 0);
        repeat (5) @(negedge clk);
        check("rst_no_write", wr_cnt[0] - wr0, 0);
        check("rst_read_count", rd_cnt[0] - rd0, 2);
        check("rst_stays_idle", busy[0], 0);

        run(0, 1'b0, 0, 3, 10, 11, 1'b0, 1'b0);   // normal run after abort
        run(1, 1'b0, 0, 0, 7, 9, 1'b1, 1'b1);     // latency 3, start while busy

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
